// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
package mips_ctrl_pkg;

  // State encodings are fixed; the bench and debug tooling rely on them.
  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StImmEx   = 4'd9,
    StImmWb   = 4'd10,
    StJump    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // Raw control word decoded from state alone. pc_write and ir_write are
  // still to be qualified by the memory handshake, branch by the zero flag.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // DECODE dispatch; unsupported opcodes fall back to FETCH.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW:     nxt = StMemAdr;
      OP_RTYPE:         nxt = StExecute;
      OP_BEQ:           nxt = StBranch;
      OP_ADDI, OP_ANDI: nxt = StImmEx;
      OP_J:             nxt = StJump;
      default:          nxt = StFetch;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> raw control word decoder for the main controller.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  // Per-state control word; anything not set stays 0, including unused encodings.
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StDecode: begin
        ctrl_o.alu_src_b = 2'b11;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      StMemWb: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      StExecute: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b00;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      StAluWb: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b00;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = 2'b01;
        ctrl_o.branch    = 1'b1;
      end
      StImmEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.alu_op    = (opcode_i == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      StImmWb: begin
        ctrl_o.reg_write = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_src   = 2'b10;
        ctrl_o.pc_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_controller.sv
// Main control FSM for the multicycle MIPS datapath with a memory req/ready handshake.
module mips_main_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               mem_req_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               pc_en_o,
  output logic               iord_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         alu_op_o,
  output logic [1:0]         pc_src_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               reg_write_o,
  output logic               illegal_op_o,
  output logic [STATE_W-1:0] state_dbg_o
);

  state_t state_q, state_d;
  state_t dec_next;
  ctrl_t  ctrl;

  assign dec_next = decode_next(opcode_i);

  mips_ctrl_outdec u_outdec (
    .state_i  (state_q),
    .opcode_i (opcode_i),
    .ctrl_o   (ctrl)
  );

  // Next-state selection, including memory stalls and opcode dispatch.
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:   state_d = mem_ready_i ? StDecode : StFetch;
      StDecode:  state_d = dec_next;
      StMemAdr:  state_d = (opcode_i == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   state_d = mem_ready_i ? StMemWb : StMemRd;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = mem_ready_i ? StFetch : StMemWr;
      StExecute: state_d = StAluWb;
      StAluWb:   state_d = StFetch;
      StBranch:  state_d = StFetch;
      StImmEx:   state_d = StImmWb;
      StImmWb:   state_d = StFetch;
      StJump:    state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake/zero qualification; every output is held low while reset is asserted.
  always_comb begin
    mem_req_o    = ctrl.mem_req;
    mem_write_o  = ctrl.mem_write;
    // A PC load tied to a memory request waits for ready; JUMP loads unconditionally.
    ir_write_o   = ctrl.ir_write & mem_ready_i;
    pc_en_o      = (ctrl.pc_write & (~ctrl.mem_req | mem_ready_i)) | (ctrl.branch & zero_i);
    iord_o       = ctrl.iord;
    alu_src_a_o  = ctrl.alu_src_a;
    alu_src_b_o  = ctrl.alu_src_b;
    alu_op_o     = ctrl.alu_op;
    pc_src_o     = ctrl.pc_src;
    reg_dst_o    = ctrl.reg_dst;
    mem_to_reg_o = ctrl.mem_to_reg;
    reg_write_o  = ctrl.reg_write;
    // Every supported opcode dispatches away from FETCH.
    illegal_op_o = (state_q == StDecode) && (dec_next == StFetch);
    if (!rst_n) begin
      mem_req_o    = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      pc_en_o      = 1'b0;
      iord_o       = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 2'b00;
      pc_src_o     = 2'b00;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
      illegal_op_o = 1'b0;
    end
  end

  assign state_dbg_o = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_main_controller.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_mips_main_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, ir_write, pc_en, iord, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  mips_main_controller #(.STATE_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode_i     (opcode),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .pc_en_o      (pc_en),
    .iord_o       (iord),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .pc_src_o     (pc_src),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .illegal_op_o (illegal_op),
    .state_dbg_o  (state_dbg)
  );

  // Word layout: mem_req mem_write ir_write pc_en iord alu_src_a alu_src_b alu_op pc_src
  //              reg_dst mem_to_reg reg_write illegal_op
  logic [15:0] got_w;
  assign got_w = {mem_req, mem_write, ir_write, pc_en, iord, alu_src_a, alu_src_b, alu_op,
                  pc_src, reg_dst, mem_to_reg, reg_write, illegal_op};

  localparam logic [15:0] W_ZERO    = 16'b0;
  localparam logic [15:0] W_FET_RDY = {4'b1011, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000};
  localparam logic [15:0] W_FET_WT  = {4'b1000, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000};
  localparam logic [15:0] W_DEC     = {4'b0000, 2'b00, 2'b11, 2'b00, 2'b00, 4'b0000};
  localparam logic [15:0] W_DEC_ILL = {4'b0000, 2'b00, 2'b11, 2'b00, 2'b00, 4'b0001};
  localparam logic [15:0] W_MEMADR  = {4'b0000, 2'b01, 2'b10, 2'b00, 2'b00, 4'b0000};
  localparam logic [15:0] W_MEMRD   = {4'b1000, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000};
  localparam logic [15:0] W_MEMWB   = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0110};
  localparam logic [15:0] W_MEMWR   = {4'b1100, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000};
  localparam logic [15:0] W_EXEC    = {4'b0000, 2'b01, 2'b00, 2'b10, 2'b00, 4'b0000};
  localparam logic [15:0] W_ALUWB   = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010};
  localparam logic [15:0] W_BR_T    = {4'b0001, 2'b01, 2'b00, 2'b01, 2'b01, 4'b0000};
  localparam logic [15:0] W_BR_NT   = {4'b0000, 2'b01, 2'b00, 2'b01, 2'b01, 4'b0000};
  localparam logic [15:0] W_IMM_ADD = {4'b0000, 2'b01, 2'b10, 2'b00, 2'b00, 4'b0000};
  localparam logic [15:0] W_IMM_AND = {4'b0000, 2'b01, 2'b10, 2'b11, 2'b00, 4'b0000};
  localparam logic [15:0] W_IMMWB   = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0010};
  localparam logic [15:0] W_JUMP    = {4'b0001, 2'b00, 2'b00, 2'b00, 2'b10, 4'b0000};

  typedef struct {
    logic [3:0]  st;
    logic [15:0] w;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: every cycle with a queued expectation is compared away from the clock edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (state_dbg !== e.st) begin
        n_fail++;
        $display("FAIL %s state: got %0d want %0d", e.name, state_dbg, e.st);
      end
      n_checks++;
      if (got_w !== e.w) begin
        n_fail++;
        $display("FAIL %s ctrl: got %b want %b", e.name, got_w, e.w);
      end
    end
  end

  // Drive one cycle of inputs and queue what the DUT must present during it.
  task automatic step(input logic [5:0] op, input logic rdy, input logic z,
                      input logic [3:0] st, input logic [15:0] w, input string nm);
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back('{st, w, nm});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'b0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(6'b100011, 1'b1, 1'b0, 4'd0, W_ZERO, "reset_hold");
    rst_n = 1'b1;

    // lw, zero-wait
    step(6'b100011, 1'b1, 1'b0, 4'd0, W_FET_RDY, "lw_fetch");
    step(6'b100011, 1'b1, 1'b0, 4'd1, W_DEC,     "lw_decode");
    step(6'b100011, 1'b1, 1'b0, 4'd2, W_MEMADR,  "lw_memadr");
    step(6'b100011, 1'b1, 1'b0, 4'd3, W_MEMRD,   "lw_memrd");
    step(6'b100011, 1'b1, 1'b0, 4'd4, W_MEMWB,   "lw_memwb");

    // sw with two wait cycles in MEMWR
    step(6'b101011, 1'b1, 1'b0, 4'd0, W_FET_RDY, "sw_fetch");
    step(6'b101011, 1'b1, 1'b0, 4'd1, W_DEC,     "sw_decode");
    step(6'b101011, 1'b1, 1'b0, 4'd2, W_MEMADR,  "sw_memadr");
    step(6'b101011, 1'b0, 1'b0, 4'd5, W_MEMWR,   "sw_memwr_w1");
    step(6'b101011, 1'b0, 1'b0, 4'd5, W_MEMWR,   "sw_memwr_w2");
    step(6'b101011, 1'b1, 1'b0, 4'd5, W_MEMWR,   "sw_memwr_done");

    // beq taken and not taken
    step(6'b000100, 1'b1, 1'b1, 4'd0, W_FET_RDY, "beq_t_fetch");
    step(6'b000100, 1'b1, 1'b1, 4'd1, W_DEC,     "beq_t_decode");
    step(6'b000100, 1'b1, 1'b1, 4'd8, W_BR_T,    "beq_t_branch");
    step(6'b000100, 1'b1, 1'b0, 4'd0, W_FET_RDY, "beq_nt_fetch");
    step(6'b000100, 1'b1, 1'b0, 4'd1, W_DEC,     "beq_nt_decode");
    step(6'b000100, 1'b1, 1'b0, 4'd8, W_BR_NT,   "beq_nt_branch");

    // R-type, andi, addi
    step(6'b000000, 1'b1, 1'b0, 4'd0,  W_FET_RDY, "rtype_fetch");
    step(6'b000000, 1'b1, 1'b0, 4'd1,  W_DEC,     "rtype_decode");
    step(6'b000000, 1'b1, 1'b0, 4'd6,  W_EXEC,    "rtype_execute");
    step(6'b000000, 1'b1, 1'b0, 4'd7,  W_ALUWB,   "rtype_aluwb");
    step(6'b001100, 1'b1, 1'b0, 4'd0,  W_FET_RDY, "andi_fetch");
    step(6'b001100, 1'b1, 1'b0, 4'd1,  W_DEC,     "andi_decode");
    step(6'b001100, 1'b1, 1'b0, 4'd9,  W_IMM_AND, "andi_immex");
    step(6'b001100, 1'b1, 1'b0, 4'd10, W_IMMWB,   "andi_immwb");
    step(6'b001000, 1'b1, 1'b0, 4'd0,  W_FET_RDY, "addi_fetch");
    step(6'b001000, 1'b1, 1'b0, 4'd1,  W_DEC,     "addi_decode");
    step(6'b001000, 1'b1, 1'b0, 4'd9,  W_IMM_ADD, "addi_immex");
    step(6'b001000, 1'b1, 1'b0, 4'd10, W_IMMWB,   "addi_immwb");

    // Illegal opcode, then a stalled fetch followed by a jump
    step(6'b111111, 1'b1, 1'b0, 4'd0,  W_FET_RDY, "ill_fetch");
    step(6'b111111, 1'b1, 1'b0, 4'd1,  W_DEC_ILL, "ill_decode");
    step(6'b000010, 1'b0, 1'b0, 4'd0,  W_FET_WT,  "stall_1");
    step(6'b000010, 1'b0, 1'b0, 4'd0,  W_FET_WT,  "stall_2");
    step(6'b000010, 1'b0, 1'b0, 4'd0,  W_FET_WT,  "stall_3");
    step(6'b000010, 1'b1, 1'b0, 4'd0,  W_FET_RDY, "j_fetch");
    step(6'b000010, 1'b1, 1'b0, 4'd1,  W_DEC,     "j_decode");
    step(6'b000010, 1'b1, 1'b0, 4'd11, W_JUMP,    "j_jump");

    // Async reset in the middle of a stalled MEMWR
    step(6'b101011, 1'b1, 1'b0, 4'd0, W_FET_RDY, "rst_sw_fetch");
    step(6'b101011, 1'b1, 1'b0, 4'd1, W_DEC,     "rst_sw_decode");
    step(6'b101011, 1'b1, 1'b0, 4'd2, W_MEMADR,  "rst_sw_memadr");
    step(6'b101011, 1'b0, 1'b0, 4'd5, W_MEMWR,   "rst_sw_memwr");
    exp_q.push_back('{4'd0, W_ZERO, "rst_async_drop"});
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back('{4'd0, W_ZERO, "rst_async_hold"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(6'b000010, 1'b1, 1'b0, 4'd0,  W_FET_RDY, "post_rst_fetch");
    step(6'b000010, 1'b1, 1'b0, 4'd1,  W_DEC,     "post_rst_decode");
    step(6'b000010, 1'b1, 1'b0, 4'd11, W_JUMP,    "post_rst_jump");
    step(6'b000010, 1'b0, 1'b0, 4'd0,  W_FET_WT,  "post_rst_refetch");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end want end before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_main_controller.md
Name: mips_main_controller

Overview:
- Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback over several cycles per instruction.
- Drives the datapath mux selects and write enables, and produces the 2-bit alu_op consumed by the ALU decoder.
- Adds a simple memory request/ready handshake so that fetch and data accesses can stall on a slow shared memory.

Parameters:
- STATE_W, 4, width of the state register (12 states used).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag, valid in the BRANCH state.
- mem_ready  in  1  memory has completed the current request in this cycle.
- mem_req  out  1  memory access requested this cycle.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- pc_en  out  1  PC load = pc_write | (branch & zero).
- iord  out  1  address mux: 0 = PC, 1 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- alu_op  out  2  to the ALU decoder: 00 add, 01 sub, 10 use funct, 11 and.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = data register.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state_dbg  out  STATE_W  current state encoding, for debug and the bench.

Behaviour:
- State encoding, fixed and exported in the package: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11.
- Reset: rst_n low asynchronously forces state to FETCH. While rst_n is low, every output is forced to 0 and state_dbg reads 0.
- Outputs are decoded combinationally from state. The exceptions qualified by mem_ready or zero are listed per state. Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=mem_ready, pc_en=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 or 001100 -> IMMEX; 000010 -> JUMP.
  - Any other opcode -> FETCH, with illegal_op=1 for that cycle.
- MEMADR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - Go to MEMRD if opcode=100011, otherwise MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Go to FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1. Hold until mem_ready, then go to FETCH. mem_write stays high for every cycle of the hold.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero.
  - Go to FETCH.
- IMMEX:
  - alu_src_a=1, alu_src_b=10.
  - alu_op=00 for addi (001000), 11 for andi (001100).
  - Go to IMMWB.
- IMMWB: reg_dst=0, mem_to_reg=0, reg_write=1. Go to FETCH.
- JUMP: pc_src=10, pc_en=1. Go to FETCH.
- Latency in cycles, with zero-wait memory: lw 5, sw 4, R-type 4, addi/andi 4, beq 3, j 3. Each memory wait cycle adds 1.
- opcode is sampled in DECODE, MEMADR and IMMEX. It must be held stable by the IR, which is written only in FETCH.
- Reset mid-instruction, including during a mem_ready hold: the FSM aborts immediately and resumes in FETCH after rst_n deasserts. No partial register or memory write occurs after the reset edge.
- Unused state encodings (12 to 15) go to FETCH on the next clock, with all outputs 0.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state enum (typedef state_t).
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_J.
  - alu_op localparams: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_AND.
- One sub-module: mips_ctrl_outdec, a purely combinational state -> control-word decoder. The top keeps the state register, next-state logic and handshake qualification.

Test Plan:
- Reset and lw, zero wait: release rst_n, mem_ready=1 constantly, opcode=100011.
  - Required: state_dbg sequence 0,1,2,3,4,0.
  - reg_write=1 and mem_to_reg=1 only in state 4.
  - ir_write and pc_en pulse once in state 0.
- sw with 2 wait cycles: opcode=101011, mem_ready low for 2 cycles in MEMWR.
  - Required: mem_write=1 for 3 consecutive cycles, then state 0.
  - Total of 6 cycles from FETCH entry, with zero-wait fetch.
- beq both ways: opcode=000100.
  - zero=1: pc_en=1, pc_src=01, alu_op=01 in BRANCH.
  - zero=0: pc_en=0 in BRANCH.
  - Both cases return to FETCH after 3 cycles.
- R-type and andi: opcode=000000 gives alu_op=10 in EXECUTE, then reg_dst=1 in ALUWB. opcode=001100 gives alu_op=11 in IMMEX, then reg_dst=0 in IMMWB.
- Illegal opcode and fetch stall: opcode=111111 gives illegal_op=1 for exactly 1 cycle in DECODE, then FETCH. mem_ready=0 for 3 cycles in FETCH gives ir_write=0 and pc_en=0 throughout.
- Async reset mid-MEMWR: assert rst_n low between clock edges while mem_write=1. Required: mem_write drops to 0 immediately, state_dbg=0 immediately, and the next instruction starts in FETCH after rst_n deasserts.
